// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl
//   Runs one Mastermind guess round. It scores a submitted guess against the
//   secret code and then sends a one-cycle command to the turn counter.
//   The scoring is serial:
//     - EXACT walks the pegs one per cycle. It counts black pegs and builds
//       per-colour histograms for the secret and for the guess.
//     - COLOR walks the colours one per cycle. It sums min(hs, hg) into the
//       total number of colour matches.
//     - ISSUE presents the command and the result for one cycle.
//
// Ports
//   i_clk, i_resetn        clock; synchronous active-low reset
//   i_secret, i_guess      codes; peg i = bits [i*COLOR_W +: COLOR_W]
//   i_submit               submit level; rising edge starts a round
//   i_current_turn         turn number from the turn counter (0 = not started)
//   i_game_over            0 = playing, 1 = lose, 2 = win
//   o_turn_cmd             2'b10 = win, 2'b01 = next turn, 2'b00 = hold
//   o_black, o_white       score of the last completed round
//   o_result_valid         one-cycle pulse while o_black/o_white are fresh (ISSUE)
//   o_busy                 round in progress (EXACT, COLOR, ISSUE)
//   o_state                debug view of the FSM state
//
// Handshake: there is no back-pressure. A submit rise is taken only in IDLE
// when the game is playing and the turn is non-zero. Any other rise is
// dropped, not queued. The command is valid for exactly the ISSUE cycle, and
// the consumer must take it on the clock edge that ends ISSUE.
module guess_round_ctrl #(
   parameter int PEGS    = 4,
   parameter int COLOR_W = 3
) (
   input  logic                        i_clk,
   input  logic                        i_resetn,
   input  logic [PEGS*COLOR_W-1:0]     i_secret,
   input  logic [PEGS*COLOR_W-1:0]     i_guess,
   input  logic                        i_submit,
   input  logic [3:0]                  i_current_turn,
   input  logic [1:0]                  i_game_over,
   output logic [1:0]                  o_turn_cmd,
   output logic [$clog2(PEGS+1)-1:0]   o_black,
   output logic [$clog2(PEGS+1)-1:0]   o_white,
   output logic                        o_result_valid,
   output logic                        o_busy,
   output logic [1:0]                  o_state
);

   localparam int NCOL  = 2 ** COLOR_W;
   localparam int CW    = $clog2(PEGS + 1);
   localparam int CNT_W = $clog2((PEGS > NCOL) ? PEGS : NCOL);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXACT = 2'd1,
      S_COLOR = 2'd2,
      S_ISSUE = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic                      r_submit_q;
   logic [PEGS*COLOR_W-1:0]   r_sec_sh;
   logic [PEGS*COLOR_W-1:0]   r_gue_sh;
   logic [CNT_W-1:0]          r_cnt;
   logic [CW-1:0]             r_black_acc;
   logic [CW-1:0]             r_tot_acc;
   logic [CW-1:0]             r_hs [NCOL];
   logic [CW-1:0]             r_hg [NCOL];
   logic [CW-1:0]             r_black;
   logic [CW-1:0]             r_white;

   logic                      w_sub_rise;
   logic                      w_accept;
   logic                      w_last;
   logic [COLOR_W-1:0]        w_sp;
   logic [COLOR_W-1:0]        w_gp;
   logic [COLOR_W-1:0]        w_col;
   logic [CW-1:0]             w_min;
   logic [CW-1:0]             w_tot_next;

   assign w_sub_rise = i_submit & ~r_submit_q;
   assign w_accept   = w_sub_rise && (i_game_over == 2'd0) && (i_current_turn != 4'd0);

   // The latched codes are shifted right one peg per EXACT cycle, so the
   // current peg is always in the low bits. No variable part-select is needed.
   assign w_sp       = r_sec_sh[COLOR_W-1:0];
   assign w_gp       = r_gue_sh[COLOR_W-1:0];
   assign w_col      = r_cnt[COLOR_W-1:0];
   assign w_min      = (r_hs[w_col] < r_hg[w_col]) ? r_hs[w_col] : r_hg[w_col];
   assign w_tot_next = r_tot_acc + w_min;
   assign w_last     = (r_state == S_EXACT) ? (r_cnt == CNT_W'(PEGS - 1))
                                            : (r_cnt == CNT_W'(NCOL - 1));

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_resetn) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   // Next state and Moore outputs
   always_comb begin
      w_next         = r_state;
      o_turn_cmd     = 2'b00;
      o_result_valid = 1'b0;
      o_busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_EXACT;
         end
         S_EXACT: begin
            o_busy = 1'b1;
            if (w_last) w_next = S_COLOR;
         end
         S_COLOR: begin
            o_busy = 1'b1;
            if (w_last) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            o_busy         = 1'b1;
            o_result_valid = 1'b1;
            o_turn_cmd     = (r_black_acc == CW'(PEGS)) ? 2'b10 : 2'b01;
            w_next         = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Scoring datapath
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_submit_q  <= 1'b0;
         r_sec_sh    <= '0;
         r_gue_sh    <= '0;
         r_cnt       <= '0;
         r_black_acc <= '0;
         r_tot_acc   <= '0;
         r_black     <= '0;
         r_white     <= '0;
         for (int c = 0; c < NCOL; c++) begin
            r_hs[c] <= '0;
            r_hg[c] <= '0;
         end
      end else begin
         r_submit_q <= i_submit;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sec_sh    <= i_secret;
                  r_gue_sh    <= i_guess;
                  r_cnt       <= '0;
                  r_black_acc <= '0;
                  r_tot_acc   <= '0;
                  for (int c = 0; c < NCOL; c++) begin
                     r_hs[c] <= '0;
                     r_hg[c] <= '0;
                  end
               end
            end
            S_EXACT: begin
               if (w_sp == w_gp) r_black_acc <= r_black_acc + CW'(1);
               // Two separate arrays, so the updates cannot collide even when
               // w_sp equals w_gp.
               r_hs[w_sp] <= r_hs[w_sp] + CW'(1);
               r_hg[w_gp] <= r_hg[w_gp] + CW'(1);
               r_sec_sh   <= r_sec_sh >> COLOR_W;
               r_gue_sh   <= r_gue_sh >> COLOR_W;
               r_cnt      <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            S_COLOR: begin
               r_tot_acc <= w_tot_next;
               r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
               // Publish the score as ISSUE begins. The total colour count
               // always covers the exact matches, so the subtraction cannot
               // go negative.
               if (w_last) begin
                  r_black <= r_black_acc;
                  r_white <= w_tot_next - r_black_acc;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_black = r_black;
   assign o_white = r_white;
   assign o_state = r_state;

endmodule

// File: tb/tb_guess_round_ctrl.sv
module tb_guess_round_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] secret;
  logic [11:0] guess;
  logic        submit;
  logic [3:0]  current_turn;
  logic [1:0]  game_over;
  logic [1:0]  turn_cmd;
  logic [2:0]  black;
  logic [2:0]  white;
  logic        result_valid;
  logic        busy;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  // Turn counter model; it is not tied to the DUT reset.
  logic       ctr_init = 1'b0;
  logic [3:0] init_turn = 4'd1;
  logic [1:0] init_go = 2'd0;
  logic [3:0] cnt_turn = 4'd1;
  logic [1:0] cnt_go = 2'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ctr_init) begin
      cnt_turn <= init_turn;
      cnt_go   <= init_go;
    end else if (turn_cmd == 2'b10) begin
      cnt_go <= 2'd2;
    end else if (turn_cmd == 2'b01) begin
      if (cnt_turn == 4'd10) cnt_go <= 2'd1;
      cnt_turn <= cnt_turn + 4'd1;
    end
  end

  assign current_turn = cnt_turn;
  assign game_over    = cnt_go;

  guess_round_ctrl dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_secret       (secret),
    .i_guess        (guess),
    .i_submit       (submit),
    .i_current_turn (current_turn),
    .i_game_over    (game_over),
    .o_turn_cmd     (turn_cmd),
    .o_black        (black),
    .o_white        (white),
    .o_result_valid (result_valid),
    .o_busy         (busy),
    .o_state        (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ctr(input logic [3:0] t, input logic [1:0] g);
    @(negedge clk);
    init_turn = t;
    init_go   = g;
    ctr_init  = 1'b1;
    @(negedge clk);
    ctr_init  = 1'b0;
  endtask

  // Count pulses over n negedge samples.
  task automatic observe(input int n, output int rv_cnt, output int c01, output int c10,
                         output int busy_cnt);
    rv_cnt = 0; c01 = 0; c10 = 0; busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
      if (turn_cmd == 2'b01) c01++;
      if (turn_cmd == 2'b10) c10++;
      if (busy) busy_cnt++;
    end
  endtask

  // One pulsed round with full latency and duration checks.
  task automatic run_round(input string tag, input logic [11:0] s, input logic [11:0] g,
                           input logic [2:0] eb, input logic [2:0] ew, input logic [1:0] ecmd);
    @(negedge clk);
    secret = s;
    guess  = g;
    submit = 1'b1;
    @(negedge clk);                    // after accept edge k
    submit = 1'b0;
    secret = 12'hFFF;                  // late changes must not matter
    guess  = 12'h000;
    chk({tag, "_busy_start"}, busy, 1'b1);
    for (int i = 0; i < 11; i++) @(negedge clk);   // after edge k+11
    chk({tag, "_rv_early"}, result_valid, 1'b0);
    @(negedge clk);                    // after edge k+12: ISSUE
    chk({tag, "_rv"}, result_valid, 1'b1);
    chk({tag, "_cmd"}, turn_cmd, ecmd);
    chk({tag, "_black"}, black, eb);
    chk({tag, "_white"}, white, ew);
    @(negedge clk);                    // ISSUE lasts one cycle
    chk({tag, "_rv_end"}, result_valid, 1'b0);
    chk({tag, "_cmd_end"}, turn_cmd, 2'b00);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_black_hold"}, black, eb);
  endtask

  int rv_c, c01, c10, bz;

  initial begin
    resetn = 1'b0;
    submit = 1'b0;
    secret = '0;
    guess  = '0;
    set_ctr(4'd1, 2'd0);
    @(negedge clk);
    chk("rst_state", state, 2'd0);
    chk("rst_cmd", turn_cmd, 2'b00);
    chk("rst_black", black, 3'd0);
    chk("rst_white", white, 3'd0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    resetn = 1'b1;

    // 1: exact match wins
    run_round("t1", 12'h8D1, 12'h8D1, 3'd4, 3'd0, 2'b10);
    chk("t1_go", cnt_go, 2'd2);

    // 2: all colours in the wrong slots
    set_ctr(4'd1, 2'd0);
    run_round("t2", 12'h8D1, 12'h29C, 3'd0, 3'd4, 2'b01);
    chk("t2_turn", cnt_turn, 4'd2);

    // 3: mixed score
    run_round("t3", 12'h489, 12'h051, 3'd1, 3'd2, 2'b01);
    chk("t3_turn", cnt_turn, 4'd3);

    // 4: submit held for 40 cycles gives one round
    @(negedge clk);
    secret = 12'h8D1;
    guess  = 12'h29C;
    submit = 1'b1;
    observe(40, rv_c, c01, c10, bz);
    submit = 1'b0;
    begin
      int r2, a2, b2, z2;
      observe(5, r2, a2, b2, z2);
      rv_c += r2; c01 += a2; c10 += b2;
    end
    chk("t4_rv_count", rv_c, 1);
    chk("t4_c01_count", c01, 1);
    chk("t4_c10_count", c10, 0);
    chk("t4_turn", cnt_turn, 4'd4);

    // 5: reset in the middle of COLOR
    @(negedge clk);
    secret = 12'h8D1;
    guess  = 12'h8D1;
    submit = 1'b1;
    @(negedge clk);                    // after accept edge k
    submit = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);    // after edge k+6
    chk("t5_in_color", state, 2'd2);
    chk("t5_white_before", white, 3'd4);
    resetn = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_black", black, 3'd0);
    chk("t5_white", white, 3'd0);
    chk("t5_cmd", turn_cmd, 2'b00);
    resetn = 1'b1;
    observe(15, rv_c, c01, c10, bz);
    chk("t5_no_cmd", c01 + c10, 0);
    chk("t5_turn", cnt_turn, 4'd4);

    // 6a: game over blocks rounds
    set_ctr(4'd4, 2'd2);
    @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    observe(15, rv_c, c01, c10, bz);
    chk("t6a_busy", bz, 0);
    chk("t6a_cmd", c01 + c10, 0);

    // 6b: turn 0 blocks rounds
    set_ctr(4'd0, 2'd0);
    @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    observe(15, rv_c, c01, c10, bz);
    chk("t6b_busy", bz, 0);
    chk("t6b_cmd", c01 + c10, 0);

    // 6c: a second rise while busy is dropped
    set_ctr(4'd5, 2'd0);
    @(negedge clk);
    secret = 12'h489;
    guess  = 12'h051;
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    observe(30, rv_c, c01, c10, bz);
    chk("t6c_rv_count", rv_c, 1);
    chk("t6c_c01_count", c01, 1);
    chk("t6c_turn", cnt_turn, 4'd6);
    chk("t6c_black", black, 3'd1);
    chk("t6c_white", white, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
